// File: rtl/lib_switch_allocator_pkg.sv
// Shared configuration for the VOQ/FIFO switch library: default port counts and pointer sizing.
// Optional feature macro LIB_SWITCH_ALLOCATOR_ISLIP_EN is consumed by lib_switch_allocator.
package lib_switch_allocator_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned M_DEF = 4;

    // Round-robin pointer width for a given number of candidates, never below one bit.
    function automatic int unsigned ptr_width(input int unsigned count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/lib_switch_allocator_if.sv
// Request/grant bus between the VOQ blocks and the switch allocator.
interface lib_switch_allocator_if
    import lib_switch_allocator_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
);

    logic [0:N-1][0:M-1] i_req;
    logic [0:N-1][0:M-1] o_grant;
    logic [0:M-1][0:N-1] o_sel;
    logic [0:M-1]        o_out_val;

    modport master (
        output i_req,
        input  o_grant,
        input  o_sel,
        input  o_out_val
    );

    modport slave (
        input  i_req,
        output o_grant,
        output o_sel,
        output o_out_val
    );

endinterface

// File: rtl/lib_rr_arbiter.sv
// Stateless round-robin arbiter: grants the first request found at or above ptr, wrapping.
module lib_rr_arbiter
    import lib_switch_allocator_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]                 req,
    input  logic [ptr_width(WIDTH)-1:0]      ptr,
    output logic [WIDTH-1:0]                 grant
);

    localparam int unsigned PW = ptr_width(WIDTH);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            idx = PW'((32'(ptr) + k) % WIDTH);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lib_switch_allocator.sv
// Single-iteration separable switch allocator (output grant, then input accept).
// Define LIB_SWITCH_ALLOCATOR_ISLIP_EN to advance output pointers only on accepted grants.
module lib_switch_allocator
    import lib_switch_allocator_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    lib_switch_allocator_if.slave   bus
);

    localparam int unsigned GPW = ptr_width(N);
    localparam int unsigned APW = ptr_width(M);

    logic [GPW-1:0] gp     [M];
    logic [GPW-1:0] gp_nxt [M];
    logic [APW-1:0] ap     [N];
    logic [APW-1:0] ap_nxt [N];

    logic [0:N-1][0:M-1] grant_q;
    logic [0:N-1][0:M-1] masked_c;
    logic [0:N-1][0:M-1] stage1_c;
    logic [0:N-1][0:M-1] accept_c;
    logic [0:M-1][0:N-1] sel_q;
    logic [0:M-1][0:N-1] sel_c;
    logic [0:M-1]        out_val_q;
    logic [0:M-1]        out_val_c;

    logic [N-1:0] col_req [M];
    logic [N-1:0] col_gnt [M];
    logic [M-1:0] row_req [N];
    logic [M-1:0] row_acc [N];

    // Channels popped on this edge still show valid; drop them from this round.
    always_comb begin
        masked_c = bus.i_req & ~grant_q;
    end

    always_comb begin
        col_req = '{default: '0};
        for (int m = 0; m < int'(M); m++) begin
            for (int n = 0; n < int'(N); n++) begin
                col_req[m][n] = masked_c[n][m];
            end
        end
    end

    for (genvar gm = 0; gm < int'(M); gm++) begin : g_out_arb
        lib_rr_arbiter #(.WIDTH(N)) u_out_arb (
            .req   (col_req[gm]),
            .ptr   (gp[gm]),
            .grant (col_gnt[gm])
        );
    end

    always_comb begin
        stage1_c = '0;
        row_req  = '{default: '0};
        for (int n = 0; n < int'(N); n++) begin
            for (int m = 0; m < int'(M); m++) begin
                stage1_c[n][m] = col_gnt[m][n];
                row_req[n][m]  = col_gnt[m][n];
            end
        end
    end

    for (genvar gn = 0; gn < int'(N); gn++) begin : g_in_arb
        lib_rr_arbiter #(.WIDTH(M)) u_in_arb (
            .req   (row_req[gn]),
            .ptr   (ap[gn]),
            .grant (row_acc[gn])
        );
    end

    always_comb begin
        accept_c  = '0;
        sel_c     = '0;
        out_val_c = '0;
        for (int n = 0; n < int'(N); n++) begin
            for (int m = 0; m < int'(M); m++) begin
                accept_c[n][m] = row_acc[n][m];
                sel_c[m][n]    = row_acc[n][m];
                out_val_c[m]   = out_val_c[m] | row_acc[n][m];
            end
        end
    end

    // Pointers move one past the winner; untouched pointers hold.
    always_comb begin
        gp_nxt = gp;
        ap_nxt = ap;
        for (int m = 0; m < int'(M); m++) begin
            for (int n = 0; n < int'(N); n++) begin
`ifdef LIB_SWITCH_ALLOCATOR_ISLIP_EN
                if (accept_c[n][m]) begin
                    gp_nxt[m] = GPW'((n + 1) % int'(N));
                end
`else
                if (stage1_c[n][m]) begin
                    gp_nxt[m] = GPW'((n + 1) % int'(N));
                end
`endif
            end
        end
        for (int n = 0; n < int'(N); n++) begin
            for (int m = 0; m < int'(M); m++) begin
                if (accept_c[n][m]) begin
                    ap_nxt[n] = APW'((m + 1) % int'(M));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q   <= '0;
            sel_q     <= '0;
            out_val_q <= '0;
            gp        <= '{default: '0};
            ap        <= '{default: '0};
        end else if (ce) begin
            grant_q   <= accept_c;
            sel_q     <= sel_c;
            out_val_q <= out_val_c;
            gp        <= gp_nxt;
            ap        <= ap_nxt;
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_sel     = sel_q;
    assign bus.o_out_val = out_val_q;

endmodule
